// File: rtl/fetch_unit.sv
// fetch_unit: PC register, imem addressing and next-PC resolution for jumps/branches
module fetch_unit #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              jp_ctrl,
  input  logic              bne_ctrl,
  input  logic              blt_ctrl,
  input  logic              is_not_equal,
  input  logic              is_less_than,
  input  logic [16:0]       imm,
  input  logic [26:0]       target,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              inst_valid,
  output logic              redirect,
  output logic              stalled,
  output logic [CNT_W-1:0]  retired_count
);
  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;
  state_t state, state_nxt;
  logic eff_jp, br_taken;
  logic [ADDR_W-1:0] br_addr;
  logic unused_target_bits;
  assign unused_target_bits = ^target[26:ADDR_W];
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= BOOT;
      pc            <= '0;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      pc    <= imem_addr;
      if (inst_valid && !stall) retired_count <= retired_count + CNT_W'(1);
    end
  end
  always_comb begin
    state_nxt = (state == BOOT) ? RUN : (stall ? STALL : RUN);
  end
  // branch offset is sign-extended then wrapped to the PC width
  always_comb begin
    inst_valid = (state != BOOT);
    stalled    = (state == STALL);
    pc_plus1   = pc + ADDR_W'(1);
    br_addr    = pc_plus1 + ADDR_W'($signed(imm));
    eff_jp     = jp_ctrl & inst_valid & ~stall;
    br_taken   = inst_valid & ~stall & ((bne_ctrl & is_not_equal) | (blt_ctrl & is_less_than));
    redirect   = eff_jp | br_taken;
    imem_addr  = !inst_valid ? '0 :
                 stall       ? pc :
                 eff_jp      ? target[ADDR_W-1:0] :
                 br_taken    ? br_addr : pc_plus1;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors with hand-computed expectations for fetch_unit
module tb_fetch_unit;
  logic clock = 0, reset = 1, stall = 0, jp_ctrl = 0, bne_ctrl = 0, blt_ctrl = 0;
  logic is_not_equal = 0, is_less_than = 0;
  logic [16:0] imm = 0;
  logic [26:0] target = 0;
  logic [11:0] imem_addr, pc, pc_plus1;
  logic inst_valid, redirect, stalled;
  logic [31:0] retired_count;
  int errors = 0, checks = 0;

  fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .jp_ctrl(jp_ctrl), .bne_ctrl(bne_ctrl),
    .blt_ctrl(blt_ctrl), .is_not_equal(is_not_equal), .is_less_than(is_less_than),
    .imm(imm), .target(target), .imem_addr(imem_addr), .pc(pc), .pc_plus1(pc_plus1),
    .inst_valid(inst_valid), .redirect(redirect), .stalled(stalled), .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    {stall, jp_ctrl, bne_ctrl, blt_ctrl, is_not_equal, is_less_than} = '0;
    imm = '0;
    target = '0;
  endtask

  task automatic jump_to(input logic [26:0] t);
    idle();
    jp_ctrl = 1;
    target = t;
    tick();
    idle();
  endtask

  initial begin
    tick();
    tick();
    #4;
    check("rst_valid", inst_valid, 0);
    check("rst_stalled", stalled, 0);
    check("rst_redirect", redirect, 0);
    check("rst_imem", imem_addr, 0);
    check("rst_pc", pc, 0);
    check("rst_pc_plus1", pc_plus1, 1);
    check("rst_count", retired_count, 0);
    tick();
    reset = 0;
    jp_ctrl = 1;
    target = 50;
    stall = 1;
    #4;
    check("boot_valid", inst_valid, 0);
    check("boot_imem", imem_addr, 0);
    check("boot_redirect", redirect, 0);
    tick();
    idle();
    #4;
    check("run_stalled", stalled, 0);
    check("run_valid", inst_valid, 1);
    for (int i = 0; i < 4; i++) begin
      check("seq_pc", pc, i);
      check("seq_count", retired_count, i);
      check("seq_redirect", redirect, 0);
      tick();
      #4;
    end
    jp_ctrl = 1;
    target = 5;
    #1;
    check("jp_imem", imem_addr, 5);
    check("jp_redirect", redirect, 1);
    tick();
    idle();
    bne_ctrl = 1;
    is_not_equal = 1;
    imm = 17'h1FFFD;
    #4;
    check("bne_pc", pc, 5);
    check("bne_redirect", redirect, 1);
    check("bne_imem", imem_addr, 3);
    tick();
    idle();
    #4;
    check("bne_next_pc", pc, 3);
    jump_to(5);
    bne_ctrl = 1;
    imm = 17'h1FFFD;
    #4;
    check("bne_nt_redirect", redirect, 0);
    check("bne_nt_imem", imem_addr, 6);
    tick();
    idle();
    #4;
    check("bne_nt_pc", pc, 6);
    check("count_8", retired_count, 8);
    jump_to(10);
    jp_ctrl = 1;
    target = 27'h0400_0FFF;
    #4;
    check("jp_hi_imem", imem_addr, 12'hFFF);
    tick();
    idle();
    #4;
    check("top_pc", pc, 12'hFFF);
    check("wrap_pc_plus1", pc_plus1, 0);
    check("wrap_imem", imem_addr, 0);
    tick();
    #4;
    check("wrap_pc", pc, 0);
    bne_ctrl = 1;
    blt_ctrl = 1;
    is_less_than = 1;
    imm = 20;
    #1;
    check("both_redirect", redirect, 1);
    check("both_imem", imem_addr, 21);
    tick();
    idle();
    blt_ctrl = 1;
    is_less_than = 1;
    imm = 17'h1FFE2;
    #4;
    check("neg_imem", imem_addr, 12'hFF8);
    tick();
    idle();
    #4;
    check("neg_pc", pc, 12'hFF8);
    check("count_13", retired_count, 13);
    jump_to(7);
    stall = 1;
    blt_ctrl = 1;
    is_less_than = 1;
    imm = 4;
    #4;
    check("pre_stall_redirect", redirect, 0);
    check("pre_stall_imem", imem_addr, 7);
    check("pre_stall_count", retired_count, 14);
    for (int i = 0; i < 2; i++) begin
      tick();
      #4;
      check("stall_pc", pc, 7);
      check("stall_flag", stalled, 1);
      check("stall_redirect", redirect, 0);
      check("stall_count", retired_count, 14);
    end
    tick();
    stall = 0;
    #4;
    check("release_redirect", redirect, 1);
    check("release_imem", imem_addr, 12);
    tick();
    idle();
    #4;
    check("release_pc", pc, 12);
    check("release_stalled", stalled, 0);
    check("release_count", retired_count, 15);
    jump_to(9);
    stall = 1;
    tick();
    jp_ctrl = 1;
    target = 33;
    reset = 1;
    #4;
    check("mid_stall_flag", stalled, 1);
    check("mid_stall_pc", pc, 9);
    tick();
    reset = 0;
    #4;
    check("rs_pc", pc, 0);
    check("rs_valid", inst_valid, 0);
    check("rs_stalled", stalled, 0);
    check("rs_count", retired_count, 0);
    check("rs_imem", imem_addr, 0);
    tick();
    idle();
    #4;
    check("rs_run_pc", pc, 0);
    check("rs_run_valid", inst_valid, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
